// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
//   Per-bit synchronous edge detector for a WIDTH-bit level input. It emits a
//   one-clock pulse on positive_edge for a 0->1 transition and on
//   negative_edge for a 1->0 transition. An optional SYNC_STAGES-deep flop
//   chain lets the block accept inputs that are asynchronous to clk.
//
//   Parameters:
//     WIDTH        number of independent input bits
//     SYNC_STAGES  synchronizer depth on `in`: 0 (input already synchronous),
//                  2 or 3
//
//   Ports:
//     clk            rising-edge system clock
//     rst            asynchronous, active-low reset (0 = reset asserted)
//     in             [WIDTH-1:0] level input
//     positive_edge  [WIDTH-1:0] one-cycle pulse per bit on a rising transition
//     negative_edge  [WIDTH-1:0] one-cycle pulse per bit on a falling transition
// -----------------------------------------------------------------------------
module edge_detect #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] positive_edge,
    output logic [WIDTH-1:0] negative_edge
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev_p1;
    logic             armed_p1;

    // Stage p0: optional synchronizer chain, s is the last flop of the chain
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_p0[i] <= '0;
                    end
                end else begin
                    sync_p0[0] <= in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_p0[i] <= sync_p0[i-1];
                    end
                end
            end

            assign s = sync_p0[SYNC_STAGES-1];
        end
    endgenerate

    // Stage p1: previous sample and armed flag. armed_p1 stays low until the
    // first clock after reset release, so the level present at release is
    // loaded into prev_p1 without being reported as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_p1  <= '0;
            armed_p1 <= 1'b0;
        end else begin
            prev_p1  <= s;
            armed_p1 <= 1'b1;
        end
    end

    // Outputs are combinational; armed_p1 clears asynchronously with rst, which
    // also kills any pulse in progress the moment reset is asserted.
    assign positive_edge = {WIDTH{armed_p1}} &  s & ~prev_p1;
    assign negative_edge = {WIDTH{armed_p1}} & ~s &  prev_p1;

endmodule

// File: tb/tb_edge_detect.sv
module tb_edge_detect;

    logic       clk;
    logic       rst1;
    logic       rst2;
    logic [0:0] in1;
    logic [0:0] pos1;
    logic [0:0] neg1;
    logic [3:0] in2;
    logic [3:0] pos2;
    logic [3:0] neg2;

    int n_vec;
    int n_err;

    edge_detect #(.WIDTH(1), .SYNC_STAGES(0)) u_dut1 (
        .clk          (clk),
        .rst          (rst1),
        .in           (in1),
        .positive_edge(pos1),
        .negative_edge(neg1)
    );

    edge_detect #(.WIDTH(4), .SYNC_STAGES(2)) u_dut2 (
        .clk          (clk),
        .rst          (rst2),
        .in           (in2),
        .positive_edge(pos2),
        .negative_edge(neg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic in_v;
        logic exp_pos;
        logic exp_neg;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    initial begin
        int pcnt;
        int ncnt;
        int gap;
        n_vec = 0;
        n_err = 0;

        // table: {in, expected positive_edge, expected negative_edge}
        vt[0]  = '{1'b0, 1'b0, 1'b1};   // first real falling edge after reset
        vt[1]  = '{1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 1'b0};   // back-to-back toggles start
        vt[6]  = '{1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b1};
        vt[13] = '{1'b0, 1'b0, 1'b0};

        // reset with input high: no spurious edge
        rst1 = 1'b0;
        rst2 = 1'b0;
        in1  = 1'b1;
        in2  = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pos1", {3'b0, pos1}, 4'b0);
        chk("rst_neg1", {3'b0, neg1}, 4'b0);
        chk("rst_pos2", pos2, 4'b0);
        chk("rst_neg2", neg2, 4'b0);
        rst1 = 1'b1;
        rst2 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            chk("hold_pos", {3'b0, pos1}, 4'b0);
            chk("hold_neg", {3'b0, neg1}, 4'b0);
        end

        // table-driven vectors: drive on falling edge, check mid-low phase,
        // then confirm the pulse is gone right after the rising edge
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in1 = vt[i].in_v;
            #1;
            chk("vec_pos", {3'b0, pos1}, {3'b0, vt[i].exp_pos});
            chk("vec_neg", {3'b0, neg1}, {3'b0, vt[i].exp_neg});
            @(posedge clk);
            #1;
            chk("vec_end_pos", {3'b0, pos1}, 4'b0);
            chk("vec_end_neg", {3'b0, neg1}, 4'b0);
        end

        // ten toggles at random spacing of 1..128 falling edges
        pcnt = 0;
        ncnt = 0;
        for (int t = 0; t < 10; t++) begin
            gap = $urandom_range(1, 128);
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                #1;
                chk("rnd_idle", {2'b0, pos1, neg1}, 4'b0);
            end
            @(negedge clk);
            in1 = ~in1;
            #1;
            chk("rnd_align", {2'b0, pos1, neg1}, {2'b0, in1, ~in1});
            if (pos1 === 1'b1) pcnt++;
            if (neg1 === 1'b1) ncnt++;
            @(posedge clk);
            #1;
            chk("rnd_width", {2'b0, pos1, neg1}, 4'b0);
        end
        chk("rnd_npos", pcnt[3:0], 4'd5);
        chk("rnd_nneg", ncnt[3:0], 4'd5);

        // asynchronous reset while a pulse is high
        @(negedge clk);
        in1 = 1'b1;
        #1;
        chk("mid_pos_before", {3'b0, pos1}, 4'b1);
        #1;
        rst1 = 1'b0;
        #1;
        chk("mid_pos_killed", {3'b0, pos1}, 4'b0);
        @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        chk("rel_unarmed", {2'b0, pos1, neg1}, 4'b0);
        @(posedge clk);
        #1;
        chk("rel_armed", {2'b0, pos1, neg1}, 4'b0);
        @(negedge clk);
        in1 = 1'b0;
        #1;
        chk("rel_neg", {3'b0, neg1}, 4'b1);
        chk("rel_pos", {3'b0, pos1}, 4'b0);
        @(posedge clk);
        #1;
        chk("rel_neg_end", {3'b0, neg1}, 4'b0);

        // wide instance with two-stage synchronizer
        @(negedge clk);
        in2 = 4'b0101;
        @(posedge clk);
        #1;
        chk("w_lat1_pos", pos2, 4'b0000);
        @(posedge clk);
        #1;
        chk("w_lat2_pos", pos2, 4'b0101);
        chk("w_lat2_neg", neg2, 4'b0000);
        @(posedge clk);
        #1;
        chk("w_end_pos", pos2, 4'b0000);
        @(negedge clk);
        in2 = 4'b0011;
        @(posedge clk);
        #1;
        chk("w2_lat1", {pos2 | neg2}, 4'b0000);
        @(posedge clk);
        #1;
        chk("w2_pos", pos2, 4'b0010);
        chk("w2_neg", neg2, 4'b0100);
        @(posedge clk);
        #1;
        chk("w2_end", {pos2 | neg2}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
